accum_seq_core: RTL and testbench

Parametrised successor to the 8-bit bus-based adder/accumulator. It holds an accumulator A, an NREGS-entry operand register file and carry/zero flags, and executes one command at a time through a valid/ready handshake using a three-state sequencer. It sits between the pin-level control decoder (top-level wrapper) and the output mux, and replaces the single fixed B register with an addressable register file and immediate operands.

---
 rtl/accum_seq_pkg.sv | 37 +++
 rtl/accum_regfile.sv | 33 +++
 rtl/accum_seq_core.sv | 129 ++++++++++++
 tb/tb_accum_seq_core.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_seq_pkg.sv
// Shared types for the accumulator sequencer: opcodes, sequencer states and
// small opcode-classification helpers used by the core datapath.
package accum_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDI  = 3'd1,
    OP_LDR  = 3'd2,
    OP_STR  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_ADDI = 3'd6,
    OP_SUBI = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_e;

  // Opcodes whose operand comes from the register file rather than the immediate.
  function automatic logic op_uses_reg(input op_e op);
    return (op == OP_LDR) || (op == OP_STR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Opcodes that subtract the operand (A + ~op + 1).
  function automatic logic op_is_sub(input op_e op);
    return (op == OP_SUB) || (op == OP_SUBI);
  endfunction

  // Opcodes that produce an adder result and update both flags.
  function automatic logic op_is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/accum_regfile.sv
// Operand register file: NREGS x WIDTH, one synchronous write port, one
// asynchronous read port, all entries cleared by the async active-low reset.
module accum_regfile #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int SELW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [SELW-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [SELW-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [NREGS];

  // Storage: clear everything on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read is combinational so the core can capture the operand in READ.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/accum_seq_core.sv
// Accumulator core: three-state sequencer (IDLE/READ/EXEC), command latch,
// operand register, adder/subtractor, carry/zero flags and operand regfile.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE; while it is low the driver must hold the
// command stable and valid. cmd_* are sampled only on the transfer edge.
// done pulses for exactly one cycle after the EXEC edge retires a command.
module accum_seq_core
  import accum_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int SELW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [SELW-1:0]  cmd_sel,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             done,
  output logic [WIDTH-1:0] acc_q,
  output logic             cf,
  output logic             zf,
  output state_e           dbg_state
);

  // Reject unsupported parameterisations at elaboration.
  if ((WIDTH < 2) || (NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_params
    $error("accum_seq_core: WIDTH must be >= 2 and NREGS a power of two >= 2");
  end

  state_e           r_state;
  logic             r_ready;
  logic             r_done;
  op_e              r_op;
  logic [SELW-1:0]  r_sel;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic             r_cf;
  logic             r_zf;

  logic [WIDTH-1:0] w_rdata;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic             w_sub;
  logic             w_we;

  // Store happens on the EXEC edge, so a following READ sees the new value.
  assign w_we = (r_state == EXEC) && (r_op == OP_STR);

  accum_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_sel),
    .i_wdata (r_acc),
    .i_raddr (r_sel),
    .o_rdata (w_rdata)
  );

  // Shared adder: subtraction is A + ~operand + 1, so carry-out means no borrow.
  assign w_sub = op_is_sub(r_op);
  assign w_b   = w_sub ? ~r_operand : r_operand;
  assign w_sum = {1'b0, r_acc} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_sub};

  // Sequencer with registered handshake, accumulator, flags and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_op      <= OP_NOP;
      r_sel     <= '0;
      r_data    <= '0;
      r_operand <= '0;
      r_acc     <= '0;
      r_cf      <= 1'b0;
      r_zf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op    <= op_e'(cmd_op);
            r_sel   <= cmd_sel;
            r_data  <= cmd_data;
            r_ready <= 1'b0;
            r_state <= READ;
          end
        end
        READ: begin
          r_operand <= op_uses_reg(r_op) ? w_rdata : r_data;
          r_state   <= EXEC;
        end
        EXEC: begin
          if (op_is_arith(r_op)) begin
            r_acc <= w_sum[WIDTH-1:0];
            r_cf  <= w_sum[WIDTH];
            r_zf  <= (w_sum[WIDTH-1:0] == '0);
          end else if ((r_op == OP_LDI) || (r_op == OP_LDR)) begin
            r_acc <= r_operand;
            r_zf  <= (r_operand == '0);
          end
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign done      = r_done;
  assign acc_q     = r_acc;
  assign cf        = r_cf;
  assign zf        = r_zf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_accum_seq_core.sv
// Directed bench for accum_seq_core: an 8-bit/4-register instance and a
// 16-bit/8-register instance, one task per scenario, summary at the end.
module tb_accum_seq_core;
  import accum_seq_pkg::*;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-bit DUT ----------------
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_sel = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       done;
  logic [7:0] acc_q;
  logic       cf;
  logic       zf;
  state_e     dbg8;

  accum_seq_core #(.WIDTH(8), .NREGS(4)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sel   (cmd_sel),
    .cmd_data  (cmd_data),
    .done      (done),
    .acc_q     (acc_q),
    .cf        (cf),
    .zf        (zf),
    .dbg_state (dbg8)
  );

  // ---------------- 16-bit DUT ----------------
  logic        v16 = 1'b0;
  logic        rdy16;
  logic [2:0]  op16 = 3'd0;
  logic [2:0]  sel16 = 3'd0;
  logic [15:0] dat16 = 16'd0;
  logic        done16;
  logic [15:0] acc16;
  logic        cf16;
  logic        zf16;
  state_e      dbg16;

  accum_seq_core #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (v16),
    .cmd_ready (rdy16),
    .cmd_op    (op16),
    .cmd_sel   (sel16),
    .cmd_data  (dat16),
    .done      (done16),
    .acc_q     (acc16),
    .cf        (cf16),
    .zf        (zf16),
    .dbg_state (dbg16)
  );

  // ---------------- driver tasks ----------------
  // Issue one command to dut8 and check the accept->done timing.
  // Returns at the negedge inside the done cycle (t2->t3).
  task automatic issue8(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] data);
    int waited;
    @(negedge clk);
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_data  = data;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL issue_ready: cmd_ready=%b required 1 within 10 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Accepted; scramble the command lines, the core must ignore them now.
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_sel   = 2'($urandom_range(0, 3));
    cmd_data  = 8'($urandom_range(0, 255));
    checks++;
    if (cmd_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL read_phase: ready=%b done=%b required 0 0", cmd_ready, done);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL exec_phase: ready=%b done=%b required 0 0", cmd_ready, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done=%b ready=%b required 1 1", done, cmd_ready);
    end
  endtask

  // Issue one command to dut16 and wait (bounded) for its done pulse.
  task automatic issue16(input logic [2:0] op, input logic [2:0] sel, input logic [15:0] data);
    int waited;
    @(negedge clk);
    op16 = op; sel16 = sel; dat16 = data; v16 = 1'b1;
    waited = 0;
    while (!rdy16 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    v16 = 1'b0;
    waited = 0;
    while (!done16 && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    if (!done16) begin
      checks++; errors++;
      $display("FAIL wide_done: done=%b required 1 within 6 cycles", done16);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (acc_q !== 8'h00 || cf !== 1'b0 || zf !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: acc=%h cf=%b zf=%b done=%b required 00 0 0 0", acc_q, cf, zf, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || dbg8 !== IDLE) begin
      errors++;
      $display("FAIL reset_ready: ready=%b state=%0d required 1 0", cmd_ready, dbg8);
    end
  endtask

  task automatic test_add_basic;
    issue8(OP_LDI, 2'd0, 8'h05);
    checks++;
    if (acc_q !== 8'h05 || zf !== 1'b0) begin
      errors++;
      $display("FAIL ldi_05: acc=%h zf=%b required 05 0", acc_q, zf);
    end
    issue8(OP_STR, 2'd1, 8'h00);
    issue8(OP_LDI, 2'd0, 8'h03);
    issue8(OP_ADD, 2'd1, 8'h00);
    checks++;
    if (acc_q !== 8'h08 || cf !== 1'b0 || zf !== 1'b0) begin
      errors++;
      $display("FAIL add_r1: acc=%h cf=%b zf=%b required 08 0 0", acc_q, cf, zf);
    end
  endtask

  task automatic test_carry_wrap;
    issue8(OP_LDI, 2'd0, 8'hFF);
    issue8(OP_STR, 2'd2, 8'h00);
    issue8(OP_LDI, 2'd0, 8'h01);
    issue8(OP_ADD, 2'd2, 8'h00);
    checks++;
    if (acc_q !== 8'h00 || cf !== 1'b1 || zf !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: acc=%h cf=%b zf=%b required 00 1 1", acc_q, cf, zf);
    end
    issue8(OP_NOP, 2'd0, 8'h5A);
    checks++;
    if (acc_q !== 8'h00 || cf !== 1'b1 || zf !== 1'b1) begin
      errors++;
      $display("FAIL nop_keep: acc=%h cf=%b zf=%b required 00 1 1", acc_q, cf, zf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single: done=%b required 0", done);
    end
  endtask

  task automatic test_subtract;
    issue8(OP_LDI, 2'd0, 8'h03);
    checks++;
    if (acc_q !== 8'h03 || cf !== 1'b1 || zf !== 1'b0) begin
      errors++;
      $display("FAIL ldi_keeps_cf: acc=%h cf=%b zf=%b required 03 1 0", acc_q, cf, zf);
    end
    issue8(OP_SUBI, 2'd0, 8'h05);
    checks++;
    if (acc_q !== 8'hFE || cf !== 1'b0 || zf !== 1'b0) begin
      errors++;
      $display("FAIL subi_borrow: acc=%h cf=%b zf=%b required FE 0 0", acc_q, cf, zf);
    end
    issue8(OP_SUBI, 2'd0, 8'hFE);
    checks++;
    if (acc_q !== 8'h00 || cf !== 1'b1 || zf !== 1'b1) begin
      errors++;
      $display("FAIL subi_zero: acc=%h cf=%b zf=%b required 00 1 1", acc_q, cf, zf);
    end
    issue8(OP_LDI, 2'd0, 8'h07);
    issue8(OP_SUB, 2'd1, 8'h00);   // R1 = 05
    checks++;
    if (acc_q !== 8'h02 || cf !== 1'b1 || zf !== 1'b0) begin
      errors++;
      $display("FAIL sub_r1: acc=%h cf=%b zf=%b required 02 1 0", acc_q, cf, zf);
    end
    issue8(OP_LDR, 2'd2, 8'h00);   // R2 = FF
    checks++;
    if (acc_q !== 8'hFF || cf !== 1'b1 || zf !== 1'b0) begin
      errors++;
      $display("FAIL ldr_r2: acc=%h cf=%b zf=%b required FF 1 0", acc_q, cf, zf);
    end
    issue8(OP_LDI, 2'd0, 8'h00);
    issue8(OP_SUB, 2'd1, 8'h00);   // 00 - 05
    checks++;
    if (acc_q !== 8'hFB || cf !== 1'b0 || zf !== 1'b0) begin
      errors++;
      $display("FAIL sub_under: acc=%h cf=%b zf=%b required FB 0 0", acc_q, cf, zf);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops  [4] = '{3'd1, 3'd6, 3'd3, 3'd4};   // LDI, ADDI, STR R0, ADD R0
    logic [7:0] dats [4] = '{8'h10, 8'h22, 8'h00, 8'h00};
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int idx = 0;
    int ndone = 0;
    int last_done = -1;
    int since_acc = 10;
    bit pending = 1'b0;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h64);
    @(negedge clk);
    cmd_op = ops[0]; cmd_sel = 2'd0; cmd_data = dats[0]; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (pending) begin
        idx++;
        since_acc = 1;
        pending = 1'b0;
        if (idx < 4) begin
          cmd_op = ops[idx]; cmd_data = dats[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        since_acc++;
      end
      if (since_acc == 1 || since_acc == 2) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_busy: cycle %0d ready=%b required 0", cyc, cmd_ready);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_done: cycle %0d acc=%h required no done", cyc, acc_q);
        end else begin
          e = exp_q.pop_front();
          if (acc_q !== e) begin
            errors++;
            $display("FAIL b2b_acc: cycle %0d acc=%h required %h", cyc, acc_q, e);
          end
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != 3) begin
            errors++;
            $display("FAIL b2b_spacing: spacing=%0d required 3", cyc - last_done);
          end
        end
        last_done = cyc;
      end
      pending = cmd_valid && cmd_ready;
      @(negedge clk);
    end
    checks++;
    if (ndone != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: done pulses=%0d left=%0d required 4 0", ndone, exp_q.size());
    end
    checks++;
    if (acc_q !== 8'h64 || cf !== 1'b0 || zf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: acc=%h cf=%b zf=%b required 64 0 0", acc_q, cf, zf);
    end
  endtask

  task automatic test_reset_mid_cmd;
    int seen_done = 0;
    issue8(OP_LDI, 2'd0, 8'hAA);
    checks++;
    if (acc_q !== 8'hAA) begin
      errors++;
      $display("FAIL ldi_aa: acc=%h required AA", acc_q);
    end
    @(negedge clk);
    cmd_op = OP_STR; cmd_sel = 2'd3; cmd_data = 8'h00; cmd_valid = 1'b1;
    @(negedge clk);   // accepted, now in READ
    cmd_valid = 1'b0;
    @(negedge clk);   // now in EXEC
    rst_n = 1'b0;
    #1;
    checks++;
    if (acc_q !== 8'h00 || cf !== 1'b0 || zf !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_regs: acc=%h cf=%b zf=%b done=%b required 00 0 0 0", acc_q, cf, zf, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_done: done pulses=%0d required 0", seen_done);
    end
    issue8(OP_LDR, 2'd3, 8'h00);
    checks++;
    if (acc_q !== 8'h00 || zf !== 1'b1) begin
      errors++;
      $display("FAIL abort_r3: acc=%h zf=%b required 00 1", acc_q, zf);
    end
  endtask

  task automatic test_wide;
    issue16(OP_LDI, 3'd0, 16'h8000);
    checks++;
    if (acc16 !== 16'h8000 || zf16 !== 1'b0) begin
      errors++;
      $display("FAIL wide_ldi: acc=%h zf=%b required 8000 0", acc16, zf16);
    end
    issue16(OP_STR, 3'd7, 16'h0000);
    issue16(OP_ADD, 3'd7, 16'h0000);
    checks++;
    if (acc16 !== 16'h0000 || cf16 !== 1'b1 || zf16 !== 1'b1) begin
      errors++;
      $display("FAIL wide_add: acc=%h cf=%b zf=%b required 0000 1 1", acc16, cf16, zf16);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_basic();
    test_carry_wrap();
    test_subtract();
    test_back_to_back();
    test_reset_mid_cmd();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
